blk_opmode_engine: RTL and testbench
====================================

// Module: blk_opmode_engine
// PURPOSE
//  Parametrised block-cipher mode-of-operation engine; successor to the fixed 128-bit CTR-only wrapper.
//  Supports ECB/CBC/OFB/CTR in both directions, with generic block width and counter width.
//  Has a valid/ready stream on the data side and start/ready pulses to the cipher core.
//  Sits between the host datapath and the Blowfish/RECTANGLE core; the core itself is not included.
// PARAMETERS
//  BLK_W  128  cipher block width in bits (data, IV, chaining register)
//  CTR_W  32   CTR-mode increment width; only counter[CTR_W-1:0] increments, upper bits fixed
// PORTS
//  Clk         in   1      clock; all logic on posedge
//  RstN        in   1      synchronous active-low reset
//  Enable      in   1      0 = abort to IDLE, drop out_valid; chain/counter retained
//  Encrypt     in   1      1 = encrypt, 0 = decrypt; latched at block accept
//  SOM         in   2      mode: 0 ECB, 1 CBC, 2 OFB, 3 CTR; latched at block accept
//  Init        in   1      1-cycle pulse: chain<=IV, counter<=IV, FSM->IDLE (abort)
//  IV          in   BLK_W  initial vector / initial counter value
//  SA          in   1      core sub-algorithm select; latched at accept, driven on core_sa
//  in_valid    in   1      input block valid
//  in_ready    out  1      engine can accept a block (IDLE & Enable & !Init)
//  in_data     in   BLK_W  plaintext (enc) or ciphertext (dec)
//  out_valid   out  1      result valid; held until out_ready
//  out_ready   in   1      downstream accepts result
//  out_data    out  BLK_W  result block
//  core_start  out  1      1-cycle pulse launching the core
//  core_encrypt out 1      core direction
//  core_sa     out  1      core SA
//  core_din    out  BLK_W  core input; stable from core_start until core_ready
//  core_ready  in   1      1-cycle pulse: core_dout valid
//  core_dout   in   BLK_W  core result
// BEHAVIOUR
//  Reset (RstN=0 at posedge): FSM IDLE; in_ready=0 during reset; out_valid=0, core_start=0,
//   core_encrypt=0, core_sa=0, out_data=0, core_din=0, chain=0, counter=0.
//  FSM: IDLE -(in_valid&in_ready)-> ISSUE -(1 cyc)-> WAIT -(core_ready)-> OUT -(out_ready)-> IDLE.
//  Accept at cycle T: in_data/SOM/Encrypt/SA captured; core_start=1 in T+1 only; core_din valid T+1 on.
//  core_ready sampled in WAIT only (ignored in other states); out_valid=1 from the next cycle.
//  in_ready is 0 in ISSUE/WAIT/OUT; next accept is possible at the earliest in the cycle after the out handshake.
//  Mode datapath (C = chain, N = counter, R = core_dout, D = captured in_data):
//   ECB:       core_din=D, core_encrypt=Encrypt, out=R; C unchanged.
//   CBC enc:   core_din=D^C, core_encrypt=1, out=R, C<=R.
//   CBC dec:   core_din=D, core_encrypt=0, out=R^C, C<=D.
//   OFB:       core_din=C, core_encrypt=1 (both directions), out=R^D, C<=R.
//   CTR:       core_din=N, core_encrypt=1 (both directions), out=R^D,
//              N[CTR_W-1:0]<=N[CTR_W-1:0]+1 (mod 2^CTR_W, no carry into N[BLK_W-1:CTR_W]).
//  C and N update on the core_ready cycle; N updates only in CTR, C only per the table.
//  Init has priority over all else except reset:
//   - loads C and N from IV and clears out_valid;
//   - an in-flight result is discarded; a core_ready arriving later is ignored (FSM already in IDLE).
//  Enable=0: FSM->IDLE, out_valid=0, core_start=0; C and N are not modified.
//  Simultaneous Init & in_valid: Init wins; block not accepted (in_ready=0 that cycle).
//  SOM/Encrypt changes while busy have no effect until the next accept.
// TESTING (core stub: R = core_din ^ 128'hA5..A5, core_ready 5 cycles after core_start)
//  1 CTR: IV=128'hDEADBEEF<<96, Init, blocks D0=0,D1=0 -> out0=IV^A5.., out1=(IV|1)^A5..; core_din shows +1.
//  2 CTR wrap, CTR_W=8: IV low byte 8'hFF, 2 blocks -> 2nd core_din low byte 8'h00, bit 8 unchanged.
//  3 CBC enc then dec with the same IV on 3 blocks -> decrypted output equals original plaintext; C tracks per the table.
//  4 OFB: same keystream for enc and dec; core_encrypt=1 while Encrypt=0; round-trip restores data.
//  5 Backpressure: hold out_ready=0 for 10 cycles -> out_valid/out_data stable, in_ready=0, no 2nd core_start.
//  6 Abort: Init pulse in WAIT -> IDLE next cycle, out_valid never set, late core_ready ignored, C=IV;
//    RstN=0 mid-block -> all outputs at reset values in the next cycle.

Source files
------------

// File: rtl/blk_opmode_engine.sv
// rtl/blk_opmode_engine.sv - ECB/CBC/OFB/CTR mode-of-operation engine around an external block-cipher core
module blk_opmode_engine #(
   parameter int BLK_W = 128,
   parameter int CTR_W = 32
) (
   input  logic             Clk,
   input  logic             RstN,
   input  logic             Enable,
   input  logic             Encrypt,
   input  logic [1:0]       SOM,
   input  logic             Init,
   input  logic [BLK_W-1:0] IV,
   input  logic             SA,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             core_start,
   output logic             core_encrypt,
   output logic             core_sa,
   output logic [BLK_W-1:0] core_din,
   input  logic             core_ready,
   input  logic [BLK_W-1:0] core_dout
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

   localparam logic [1:0] M_ECB = 2'd0;
   localparam logic [1:0] M_CBC = 2'd1;
   localparam logic [1:0] M_OFB = 2'd2;
   localparam logic [1:0] M_CTR = 2'd3;

   // Only the low CTR_W bits of the counter advance; the rest is a fixed nonce.
   localparam logic [BLK_W-1:0] LOW_MASK = ~({BLK_W{1'b1}} << CTR_W);
   localparam logic [BLK_W-1:0] ONE      = BLK_W'(1);

   state_t           state;
   logic [BLK_W-1:0] chain;
   logic [BLK_W-1:0] ctr;
   logic [BLK_W-1:0] d_reg;
   logic [1:0]       mode_reg;
   logic             enc_reg;

   logic             accept;
   logic [BLK_W-1:0] din_next;
   logic             cenc_next;
   logic [BLK_W-1:0] res_data;
   logic [BLK_W-1:0] chain_next;
   logic [BLK_W-1:0] ctr_inc;

   assign in_ready = RstN && Enable && !Init && (state == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign ctr_inc  = (ctr & ~LOW_MASK) | ((ctr + ONE) & LOW_MASK);

   always_comb begin
      din_next  = in_data;
      cenc_next = 1'b1;
      case (SOM)
         M_ECB: cenc_next = Encrypt;
         M_CBC: begin
            cenc_next = Encrypt;
            din_next  = Encrypt ? (in_data ^ chain) : in_data;
         end
         M_OFB: din_next = chain;
         M_CTR: din_next = ctr;
         default: din_next = in_data;
      endcase
   end

   always_comb begin
      res_data   = core_dout;
      chain_next = chain;
      case (mode_reg)
         M_ECB: res_data = core_dout;
         M_CBC: begin
            res_data   = enc_reg ? core_dout : (core_dout ^ chain);
            chain_next = enc_reg ? core_dout : d_reg;
         end
         M_OFB: begin
            res_data   = core_dout ^ d_reg;
            chain_next = core_dout;
         end
         M_CTR: res_data = core_dout ^ d_reg;
         default: res_data = core_dout;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         state        <= S_IDLE;
         chain        <= '0;
         ctr          <= '0;
         d_reg        <= '0;
         mode_reg     <= M_ECB;
         enc_reg      <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         core_start   <= 1'b0;
         core_encrypt <= 1'b0;
         core_sa      <= 1'b0;
         core_din     <= '0;
      end else if (Init) begin
         state      <= S_IDLE;
         chain      <= IV;
         ctr        <= IV;
         out_valid  <= 1'b0;
         core_start <= 1'b0;
      end else if (!Enable) begin
         state      <= S_IDLE;
         out_valid  <= 1'b0;
         core_start <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  d_reg        <= in_data;
                  mode_reg     <= SOM;
                  enc_reg      <= Encrypt;
                  core_sa      <= SA;
                  core_encrypt <= cenc_next;
                  core_din     <= din_next;
                  core_start   <= 1'b1;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               core_start <= 1'b0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (core_ready) begin
                  out_data  <= res_data;
                  out_valid <= 1'b1;
                  chain     <= chain_next;
                  if (mode_reg == M_CTR) ctr <= ctr_inc;
                  state     <= S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blk_opmode_engine.sv
// tb/tb_blk_opmode_engine.sv - directed table-driven bench for blk_opmode_engine with an XOR core stub
module tb_blk_opmode_engine;

   localparam int BW = 128;
   localparam int CW = 8;
   localparam logic [BW-1:0] K    = {16{8'hA5}};
   localparam logic [BW-1:0] IV1  = 128'hDEADBEEF_00000000_00000000_00000000;
   localparam logic [BW-1:0] IV2  = 128'h01234567_89ABCDEF_00000000_000001FF;
   localparam logic [BW-1:0] IV2W = 128'h01234567_89ABCDEF_00000000_00000100;
   localparam logic [BW-1:0] V    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [BW-1:0] IV4  = 128'hFEEDFACE_0BADF00D_13579BDF_2468ACE0;
   localparam logic [BW-1:0] P0   = 128'h00000000_00000000_00000000_00000001;
   localparam logic [BW-1:0] P1   = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
   localparam logic [BW-1:0] P2   = 128'h55555555_AAAAAAAA_0000FFFF_FFFF0000;
   localparam logic [BW-1:0] C0   = P0 ^ V ^ K;
   localparam logic [BW-1:0] C1   = P1 ^ P0 ^ V;
   localparam logic [BW-1:0] C2   = P2 ^ P1 ^ P0 ^ V ^ K;

   logic          Clk = 1'b0;
   logic          RstN, Enable, Encrypt, Init, SA, in_valid, out_ready;
   logic [1:0]    SOM;
   logic [BW-1:0] IV, in_data;
   logic          in_ready, out_valid, core_start, core_encrypt, core_sa;
   logic [BW-1:0] out_data, core_din;
   logic          core_ready = 1'b0;
   logic [BW-1:0] core_dout  = '0;

   int n_checks = 0;
   int n_fail   = 0;

   blk_opmode_engine #(.BLK_W(BW), .CTR_W(CW)) dut (
      .Clk(Clk), .RstN(RstN), .Enable(Enable), .Encrypt(Encrypt), .SOM(SOM),
      .Init(Init), .IV(IV), .SA(SA), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .core_start(core_start), .core_encrypt(core_encrypt),
      .core_sa(core_sa), .core_din(core_din), .core_ready(core_ready),
      .core_dout(core_dout)
   );

   always #5 Clk = ~Clk;

   // Core stub: result = din ^ A5.., core_ready 5 cycles after core_start.
   logic [BW-1:0] stub_din = '0;
   int            stub_cnt = 0;
   always @(posedge Clk) begin
      core_ready <= 1'b0;
      if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) begin
            core_ready <= 1'b1;
            core_dout  <= stub_din ^ K;
         end
      end
      if (core_start) begin
         stub_cnt <= 4;
         stub_din <= core_din;
      end
   end

   typedef struct {
      bit            init;
      logic [BW-1:0] iv;
      logic [1:0]    mode;
      bit            enc;
      bit            sa;
      logic [BW-1:0] data;
      logic [BW-1:0] exp_din;
      bit            exp_cenc;
      logic [BW-1:0] exp_out;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(bit init, logic [BW-1:0] iv, logic [1:0] m, bit e, bit s,
                               logic [BW-1:0] d, logic [BW-1:0] xd, bit xc, logic [BW-1:0] xo);
      vec_t v;
      v.init = init; v.iv = iv; v.mode = m; v.enc = e; v.sa = s;
      v.data = d; v.exp_din = xd; v.exp_cenc = xc; v.exp_out = xo;
      return v;
   endfunction

   task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic pulse_init(input logic [BW-1:0] iv);
      Init = 1'b1;
      IV   = iv;
      @(negedge Clk);
      Init = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge of the cycle after the accept.
   task automatic send_block(input logic [1:0] m, input bit e, input bit s, input logic [BW-1:0] d);
      int n = 0;
      #1;
      SOM = m; Encrypt = e; SA = s; in_data = d; in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!in_ready) fail_timeout("accept");
      @(negedge Clk);
      in_valid = 1'b0;
      SOM = ~m; Encrypt = ~e;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!out_valid) fail_timeout("out_valid");
   endtask

   logic [BW-1:0] hold;
   int            cnt;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      RstN = 1'b0; Enable = 1'b1; Encrypt = 1'b0; Init = 1'b0; SA = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; SOM = 2'd0; IV = '0; in_data = '0;

      vecs[0]  = mk(1, IV1, 2'd3, 1, 0, '0,          IV1,        1, IV1 ^ K);
      vecs[1]  = mk(0, '0,  2'd3, 1, 1, '0,          IV1 | 2'd1, 1, (IV1 | 2'd1) ^ K);
      vecs[2]  = mk(0, '0,  2'd3, 0, 0, P0,          IV1 | 2'd2, 1, (IV1 | 2'd2) ^ K ^ P0);
      vecs[3]  = mk(1, IV2, 2'd3, 1, 0, '0,          IV2,        1, IV2 ^ K);
      vecs[4]  = mk(0, '0,  2'd3, 1, 0, '0,          IV2W,       1, IV2W ^ K);
      vecs[5]  = mk(1, V,   2'd1, 1, 0, P0,          P0 ^ V,     1, C0);
      vecs[6]  = mk(0, '0,  2'd1, 1, 1, P1,          P1 ^ C0,    1, C1);
      vecs[7]  = mk(0, '0,  2'd1, 1, 0, P2,          P2 ^ C1,    1, C2);
      vecs[8]  = mk(1, V,   2'd1, 0, 0, C0,          C0,         0, P0);
      vecs[9]  = mk(0, '0,  2'd1, 0, 0, C1,          C1,         0, P1);
      vecs[10] = mk(0, '0,  2'd1, 0, 1, C2,          C2,         0, P2);
      vecs[11] = mk(1, V,   2'd2, 1, 0, P0,          V,          1, V ^ K ^ P0);
      vecs[12] = mk(0, '0,  2'd2, 1, 0, P1,          V ^ K,      1, V ^ P1);
      vecs[13] = mk(1, V,   2'd2, 0, 0, V ^ K ^ P0,  V,          1, P0);
      vecs[14] = mk(0, '0,  2'd2, 0, 0, V ^ P1,      V ^ K,      1, P1);
      vecs[15] = mk(0, '0,  2'd0, 0, 1, P2,          P2,         0, P2 ^ K);
      vecs[16] = mk(0, '0,  2'd0, 1, 0, P1,          P1,         1, P1 ^ K);
      vecs[17] = mk(0, '0,  2'd2, 1, 0, '0,          V,          1, V ^ K);

      repeat (3) @(negedge Clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_encrypt", core_encrypt, 0);
      chk("rst_core_sa", core_sa, 0);
      chk("rst_out_data", out_data, '0);
      chk("rst_core_din", core_din, '0);
      RstN = 1'b1;
      @(negedge Clk);
      chk("idle_in_ready", in_ready, 1);

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].init) pulse_init(vecs[i].iv);
         send_block(vecs[i].mode, vecs[i].enc, vecs[i].sa, vecs[i].data);
         chk($sformatf("v%0d_core_start", i), core_start, 1);
         chk($sformatf("v%0d_core_din", i), core_din, vecs[i].exp_din);
         chk($sformatf("v%0d_core_encrypt", i), core_encrypt, vecs[i].exp_cenc);
         chk($sformatf("v%0d_core_sa", i), core_sa, vecs[i].sa);
         @(negedge Clk);
         chk($sformatf("v%0d_start_pulse", i), core_start, 0);
         wait_valid();
         chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_out);
         @(negedge Clk);
      end

      // Backpressure: result held, no new launch while out_ready is low.
      out_ready = 1'b0;
      send_block(2'd0, 1, 0, P0);
      wait_valid();
      hold = out_data;
      chk("bp_data", hold, P0 ^ K);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_data", out_data, hold);
         chk("bp_in_ready", in_ready, 0);
         cnt += int'(core_start);
      end
      chk("bp_no_restart", cnt, 0);
      out_ready = 1'b1;
      @(negedge Clk);
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);

      // Enable low drops a pending result.
      out_ready = 1'b0;
      send_block(2'd0, 1, 0, P1);
      wait_valid();
      Enable = 1'b0;
      @(negedge Clk);
      chk("en_out_valid", out_valid, 0);
      chk("en_in_ready", in_ready, 0);
      Enable = 1'b1;
      out_ready = 1'b1;
      @(negedge Clk);
      chk("en_idle_ready", in_ready, 1);

      // Init during WAIT: discarded result, late core_ready ignored, chain = IV.
      send_block(2'd0, 1, 0, P2);
      @(negedge Clk);
      pulse_init(IV4);
      #1;
      chk("abort_in_ready", in_ready, 1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         cnt += int'(out_valid);
      end
      chk("abort_no_out_valid", cnt, 0);
      send_block(2'd2, 1, 0, '0);
      chk("abort_chain_iv", core_din, IV4);
      wait_valid();
      chk("abort_ofb_out", out_data, IV4 ^ K);
      @(negedge Clk);

      // Init and in_valid together: Init wins, nothing launched.
      #1;
      Init = 1'b1; IV = V; in_valid = 1'b1; SOM = 2'd0; in_data = P0;
      #1;
      chk("init_vs_valid_ready", in_ready, 0);
      @(negedge Clk);
      Init = 1'b0; in_valid = 1'b0;
      #1;
      chk("init_vs_valid_start", core_start, 0);
      chk("init_vs_valid_idle", in_ready, 1);
      send_block(2'd2, 1, 0, '0);
      chk("init_vs_valid_chain", core_din, V);
      wait_valid();
      @(negedge Clk);

      // Reset mid-block.
      send_block(2'd0, 1, 1, P1);
      RstN = 1'b0;
      @(negedge Clk);
      chk("mrst_in_ready", in_ready, 0);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_core_start", core_start, 0);
      chk("mrst_core_encrypt", core_encrypt, 0);
      chk("mrst_core_sa", core_sa, 0);
      chk("mrst_out_data", out_data, '0);
      chk("mrst_core_din", core_din, '0);
      RstN = 1'b1;
      repeat (10) @(negedge Clk);
      chk("mrst_no_out_valid", out_valid, 0);
      send_block(2'd2, 1, 0, '0);
      chk("mrst_chain_zero", core_din, '0);
      wait_valid();
      chk("mrst_ofb_out", out_data, K);
      @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
